// File: rtl/piso_serializer_16b_pkg.sv
// rtl/piso_serializer_16b_pkg.sv - shared types and defaults for the PISO serializer
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH        = 16;
  localparam int SER_CLKS_PER_BIT = 4;

  // Counter width that stays at least one bit for degenerate counts
  function automatic int ser_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_16b_bit_tick_gen.sv
// rtl/piso_serializer_16b_bit_tick_gen.sv - bit-period divider, one-cycle tick on terminal count
module bit_tick_gen
  import serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = SER_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int DW = ser_cnt_w(CLKS_PER_BIT);

  logic [DW-1:0] div;

  // With CLKS_PER_BIT=1 the counter never leaves zero, so every enabled cycle ticks
  assign tick = en && (div == DW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clear || tick) begin
      div <= '0;
    end else if (en) begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer_16b.sv
// rtl/piso_serializer_16b.sv - parallel-in / serial-out transmitter, MSB first
module piso_serializer_16b
  import serializer_pkg::*;
#(
  parameter int WIDTH        = SER_WIDTH,
  parameter int CLKS_PER_BIT = SER_CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         D,
  output logic                     load_ready,
  output logic                     sout,
  output logic                     sout_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done
);

  localparam int BW = $clog2(WIDTH);

  ser_state_t     state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]  bit_cnt;
  logic           tick;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state != SHIFT),
    .en   (state == SHIFT),
    .tick (tick)
  );

  // The shift register drains to zero, but gate anyway so idle/done never leak data
  assign sout = sout_valid & shreg[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      load_ready <= 1'b1;
      sout_valid <= 1'b0;
      bit_idx    <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg      <= D;
            bit_cnt    <= '0;
            state      <= SHIFT;
            load_ready <= 1'b0;
            sout_valid <= 1'b1;
            bit_idx    <= BW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          if (tick) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == BW'(WIDTH - 1)) begin
              state      <= DONE;
              sout_valid <= 1'b0;
              bit_idx    <= '0;
              done       <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              bit_idx <= bit_idx - BW'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer_16b.sv
// tb/tb_piso_serializer_16b.sv - bench for piso_serializer_16b at CLKS_PER_BIT 4 and 1
module tb_piso_serializer_16b;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0]       lv;
  logic [1:0][15:0] d;
  logic [1:0]       lr, so, sv, dn;
  logic [1:0][3:0]  bi;

  always #5 clk = ~clk;

  piso_serializer_16b #(.WIDTH(16), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .D(d[0]),
    .load_ready(lr[0]), .sout(so[0]), .sout_valid(sv[0]), .bit_idx(bi[0]), .done(dn[0])
  );

  piso_serializer_16b #(.WIDTH(16), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .D(d[1]),
    .load_ready(lr[1]), .sout(so[1]), .sout_valid(sv[1]), .bit_idx(bi[1]), .done(dn[1])
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference: a frame is just (handshake edge k, word w); everything else is arithmetic on cycle - k
  int         cpb [2] = '{4, 1};
  longint     cyc = 0;
  longint     k   [2] = '{0, 0};
  bit         act [2] = '{0, 0};
  logic [15:0] w  [2];
  bit         chk_on = 0;

  always @(negedge rst_n) begin
    act[0] = 0;
    act[1] = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if ((!act[i] || (cyc - k[i]) > W * cpb[i] + 1) && lv[i] === 1'b1) begin
          act[i] = 1;
          k[i]   = cyc;
          w[i]   = d[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    longint t;
    int     n;
    logic   e_sh, e_dn;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        t    = cyc + 1 - k[i];
        e_sh = act[i] && t >= 1 && t <= W * cpb[i];
        e_dn = act[i] && t == W * cpb[i] + 1;
        chk($sformatf("load_ready[%0d]", i), lr[i], !(e_sh || e_dn));
        chk($sformatf("sout_valid[%0d]", i), sv[i], e_sh);
        chk($sformatf("done[%0d]", i), dn[i], e_dn);
        if (e_sh) begin
          n = int'((t - 1) / cpb[i]);
          chk($sformatf("sout[%0d]", i), so[i], w[i][15-n]);
          chk($sformatf("bit_idx[%0d]", i), bi[i], 15 - n);
        end else begin
          chk($sformatf("sout idle[%0d]", i), so[i], 0);
        end
      end
    end
  end

  task automatic run_frame4(input logic [15:0] word, input logic [15:0] d_after, input bit keep,
                            output logic [15:0] got, output int nval, output int done_t, output int t2);
    int n;
    n = 0; got = '0; nval = 0; done_t = -1; t2 = -1;
    @(negedge clk);
    lv[0] = 1'b1;
    d[0]  = word;
    while (lr[0] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout("frame handshake");
    @(posedge clk);
    #1;
    d[0]  = d_after;
    lv[0] = keep;
    for (int t = 1; t <= 68; t++) begin
      @(negedge clk);
      if (t <= 65 && sv[0]) nval++;
      if (t <= 64 && (t - 1) % 4 == 1) got = {got[14:0], so[0]};
      if (dn[0] && done_t < 0) done_t = t;
      if (t > 65 && sv[0] && t2 < 0) t2 = t;
    end
    lv[0] = 1'b0;
  endtask

  initial begin
    logic [15:0] got;
    int nval, done_t, t2, n, nhs, ns;
    longint hs [2];
    logic [31:0] stream;

    lv = '0;
    d  = '0;
    #1 rst_n = 1'b0;
    chk_on = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset load_ready", lr[0], 1);
      chk("reset sout", so[0], 0);
      chk("reset sout_valid", sv[0], 0);
      chk("reset done", dn[0], 0);
      chk("reset bit_idx", bi[0], 0);
    end
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle load_ready", lr[0], 1);
      chk("idle sout_valid", sv[0], 0);
      chk("idle done", dn[0], 0);
    end

    run_frame4(16'hA5C3, 16'h0000, 0, got, nval, done_t, t2);
    chk("A5C3 mid-bit samples", got, 16'hA5C3);
    chk("A5C3 valid cycles", nval, 64);
    chk("A5C3 done offset", done_t, 65);

    run_frame4(16'h0001, 16'hFFFF, 1, got, nval, done_t, t2);
    chk("busy first frame", got, 16'h0001);
    chk("busy done offset", done_t, 65);
    chk("busy second frame start", t2, 67);

    run_frame4(16'h1234, 16'hFFFF, 0, got, nval, done_t, t2);
    chk("D changed after handshake", got, 16'h1234);

    nhs = 0; ns = 0; stream = '0; hs[0] = 0; hs[1] = 0;
    @(negedge clk);
    lv[1] = 1'b1;
    d[1]  = 16'h8000;
    for (int i = 0; i < 45; i++) begin
      if (i > 0) @(negedge clk);
      if (sv[1]) begin
        stream = {stream[30:0], so[1]};
        ns++;
      end
      if (lr[1] && lv[1] && nhs < 2) begin
        hs[nhs] = cyc + 1;
        nhs++;
      end
      @(posedge clk);
      #1;
      if (nhs == 1) d[1] = 16'h7FFF;
      else if (nhs == 2) lv[1] = 1'b0;
    end
    chk("b2b handshakes", nhs, 2);
    chk("b2b spacing", 32'(hs[1] - hs[0]), 18);
    chk("b2b bit count", ns, 32);
    chk("b2b stream", stream, 32'h80007FFF);

    n = 0;
    @(negedge clk);
    lv[0] = 1'b1;
    d[0]  = 16'h5555;
    while (lr[0] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout("reset frame handshake");
    @(posedge clk);
    #1 lv[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("bit7 sout_valid", sv[0], 1);
    chk("bit7 bit_idx", bi[0], 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset sout", so[0], 0);
    chk("async reset sout_valid", sv[0], 0);
    repeat (3) begin
      @(negedge clk);
      chk("no done in reset", dn[0], 0);
    end
    #1 rst_n = 1'b1;
    run_frame4(16'h00FF, 16'h0000, 0, got, nval, done_t, t2);
    chk("post-reset frame", got, 16'h00FF);
    chk("post-reset done offset", done_t, 65);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      lv[0] = ($urandom_range(0, 3) == 0);
      d[0]  = 16'($urandom);
      lv[1] = ($urandom_range(0, 2) == 0);
      d[1]  = 16'($urandom);
      if (i == 200) #2 rst_n = 1'b0;
      if (i == 203) #2 rst_n = 1'b1;
    end
    lv = '0;
    repeat (80) @(negedge clk);
    chk_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
